// File: rtl/tetris_input_pkg.sv
// Shared constants for the player-input front end: KEY bit positions and
// the auto-repeat state encoding used by input_conditioner.
// Pure declarations, no logic; no latency or backpressure.
package tetris_input_pkg;

  // Bit positions within the raw KEY bus
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_ROT   = 2;
  localparam int K_DROP  = 3;

  // Auto-repeat state per left/right button
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_RPT   = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side bundle for input_conditioner: raw KEYs and gravity enable in,
// one-cycle move/rotate/gravity pulses out.
// No flow control: pulses are fire-and-forget, the consumer must sample every cycle.
interface input_conditioner_if;
  logic [3:0] KEY;
  logic       gravity_en;
  logic       left_final;
  logic       right_final;
  logic       rot_final;
  logic       tick_gravity;

  // Board/game-logic side: drives buttons and gravity enable, consumes pulses
  modport master (
    output KEY, gravity_en,
    input  left_final, right_final, rot_final, tick_gravity
  );

  // Conditioner side
  modport slave (
    input  KEY, gravity_en,
    output left_final, right_final, rot_final, tick_gravity
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser (inverted to active-high), debounce counter, stable level, press pulse.
// Latency: DB_CYCLES+3 edges from first sampling of a clean new level to the press pulse.
// No backpressure; press is a single-cycle pulse on each accepted 0->1 of the stable level.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable_d;
  logic [DW-1:0] cnt;

  // Synchronise, require DB_CYCLES of disagreement before flipping stable, then register the rising edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      meta     <= ~key_n;
      sync     <= meta;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Player-input front end: debounced KEY press pulses with left/right conflict masking, plus gravity ticks
// with soft-drop speed-up. Optional INPUT_AUTOREPEAT_EN adds held-button auto-repeat on left/right.
// No backpressure: all outputs are one-cycle pulses; press latency DB_CYCLES+3 edges, first tick P edges after gravity_en.
module input_conditioner
  import tetris_input_pkg::*;
#(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int GRAV_CYCLES  = 25_000_000,
  parameter int FAST_DIV     = 8,
  parameter int REPEAT_DELAY = 15_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input logic                CLOCK_50,
  input logic                resetn,
  input_conditioner_if.slave io
);

  logic [3:0] stable;
  logic [3:0] press;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .key_n  (io.KEY[gi]),
      .stable (stable[gi]),
      .press  (press[gi])
    );
  end

  // ---------------- gravity ----------------
  localparam int GW = (GRAV_CYCLES > 1) ? $clog2(GRAV_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST_NORM = GW'(GRAV_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST_FAST = GW'(GRAV_CYCLES / FAST_DIV - 1);

  logic [GW-1:0] gcnt;
  logic [GW-1:0] g_last;
  logic          tick_q;

  assign g_last = stable[K_DROP] ? G_LAST_FAST : G_LAST_NORM;

  // Gravity period counter; >= compare lets a mid-count speed-up tick immediately
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      gcnt   <= '0;
      tick_q <= 1'b0;
    end else if (!io.gravity_en) begin
      gcnt   <= '0;
      tick_q <= 1'b0;
    end else if (gcnt >= g_last) begin
      gcnt   <= '0;
      tick_q <= 1'b1;
    end else begin
      gcnt   <= gcnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign io.tick_gravity = tick_q;

  // ---------------- left/right sources ----------------
  logic left_q;
  logic right_q;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] R_LAST_DELAY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_LAST_RATE  = RW'(REPEAT_RATE - 1);

  logic [1:0] rpt;

  // Index 0 = K_LEFT, index 1 = K_RIGHT
  for (genvar ri = 0; ri < 2; ri++) begin : g_rpt
    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          rpt_pulse;

    // Repeat state register
    always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
        state <= R_IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // Delay then periodic repeat while held; any release returns to idle
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rpt_pulse = 1'b0;
      if (!stable[ri]) begin
        state_nxt = R_IDLE;
        rcnt_nxt  = '0;
      end else begin
        case (state)
          R_IDLE: begin
            if (press[ri]) begin
              state_nxt = R_DELAY;
              rcnt_nxt  = '0;
            end
          end
          R_DELAY: begin
            if (rcnt == R_LAST_DELAY) begin
              rpt_pulse = 1'b1;
              state_nxt = R_RPT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
          R_RPT: begin
            if (rcnt == R_LAST_RATE) begin
              rpt_pulse = 1'b1;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
          default: begin
            state_nxt = R_IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end
    end

    assign rpt[ri] = rpt_pulse;
  end

  assign left_q  = press[K_LEFT]  | rpt[0];
  assign right_q = press[K_RIGHT] | rpt[1];

  logic unused_bits;
  assign unused_bits = ^{stable[K_ROT], press[K_DROP]};
`else
  assign left_q  = press[K_LEFT];
  assign right_q = press[K_RIGHT];

  logic unused_bits;
  assign unused_bits = ^{stable[K_LEFT], stable[K_RIGHT], stable[K_ROT], press[K_DROP]};
`endif

  // Simultaneous left and right cancel each other; rotate is independent
  assign io.left_final  = left_q & ~right_q;
  assign io.right_final = right_q & ~left_q;
  assign io.rot_final   = press[K_ROT];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with small parameters (DB=4, GRAV=10, FAST_DIV=2, DELAY=8, RATE=3).
// Checks all four output pulses after every clock edge against hand-computed edge numbers.
// Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
module tb_input_conditioner;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  input_conditioner_if bus ();

  input_conditioner #(
    .DB_CYCLES    (4),
    .GRAV_CYCLES  (10),
    .FAST_DIV     (2),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (3)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .io       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp bit order: {left, right, rot, tick}
  task automatic check(input string tag, input int edge_no, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.left_final, bus.right_final, bus.rot_final, bus.tick_gravity};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed {l,r,rot,tick}=%b expected %b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.KEY        = 4'hF;
    bus.gravity_en = 1'b0;
    resetn         = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("reset", i, 4'b0000);
    end
    resetn = 1'b1;
  endtask

  initial begin
    logic [3:0] exp;

    // 1: reset with all keys pressed and gravity enabled
    bus.KEY        = 4'b0000;
    bus.gravity_en = 1'b1;
    resetn         = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("t1_in_reset", i, 4'b0000);
    end
    resetn = 1'b1;
    step();
    check("t1_first_after_release", 1, 4'b0000);

    // 2: bouncing left key, then clean press -> single pulse 7 edges after settle
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.KEY[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      check("t2_bounce", i, 4'b0000);
    end
    bus.KEY[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i == 7) ? 4'b1000 : 4'b0000;
      check("t2_settle", i, exp);
    end

    // 3: normal gravity period 10, then gravity disabled
    do_reset();
    bus.gravity_en = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step();
      exp = (i % 10 == 0) ? 4'b0001 : 4'b0000;
      check("t3_grav", i, exp);
    end
    bus.gravity_en = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check("t3_grav_off", i, 4'b0000);
    end

    // 4: soft drop pressed as gravity starts: stable at edge 6, gcnt=6 >= 4 ticks at 7,
    //    then every 5; release after edge 22 -> tick at 27, slow period from edge 28 -> 37, 47
    do_reset();
    bus.KEY[3]     = 1'b0;
    bus.gravity_en = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      exp = (i == 7 || i == 12 || i == 17 || i == 22 || i == 27 || i == 37 || i == 47)
            ? 4'b0001 : 4'b0000;
      check("t4_fast_grav", i, exp);
      if (i == 22) bus.KEY[3] = 1'b1;
    end

    // 5a: left and right together cancel
    do_reset();
    bus.KEY = 4'b1100;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("t5_lr_conflict", i, 4'b0000);
    end

    // 5b: left and rotate together both fire
    do_reset();
    bus.KEY = 4'b1010;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = (i == 7) ? 4'b1010 : 4'b0000;
      check("t5_left_rot", i, exp);
    end

    // 6: right held 30 cycles past its press pulse (pulse at edge 7)
    do_reset();
    bus.KEY[1] = 1'b0;
    for (int i = 1; i <= 37; i++) begin
      step();
`ifdef INPUT_AUTOREPEAT_EN
      exp = (i == 7 || (i >= 15 && (i - 15) % 3 == 0)) ? 4'b0100 : 4'b0000;
`else
      exp = (i == 7) ? 4'b0100 : 4'b0000;
`endif
      check("t6_right_hold", i, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
